// File: rtl/sp_ram_arbiter.sv
// Two-master round-robin arbiter with burst cap in front of the single-port data RAM.
// Optional wait-cycle counters per master when SP_RAM_ARB_PERF_EN is defined.
module sp_ram_arbiter #(
   parameter int unsigned ADDR_WIDTH = 15,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MAX_BURST  = 8
) (
   input  logic                    clk,
   input  logic                    rst_i,
   input  logic                    m0_req_i,
   output logic                    m0_gnt_o,
   input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
   input  logic                    m0_we_i,
   input  logic [DATA_WIDTH/8-1:0] m0_be_i,
   input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
   output logic                    m0_rvalid_o,
   output logic [DATA_WIDTH-1:0]   m0_rdata_o,
   input  logic                    m1_req_i,
   output logic                    m1_gnt_o,
   input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
   input  logic                    m1_we_i,
   input  logic [DATA_WIDTH/8-1:0] m1_be_i,
   input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
   output logic                    m1_rvalid_o,
   output logic [DATA_WIDTH-1:0]   m1_rdata_o,
   output logic                    ram_en_o,
   output logic [ADDR_WIDTH-1:0]   ram_addr_o,
   output logic                    ram_we_o,
   output logic [DATA_WIDTH/8-1:0] ram_be_o,
   output logic [DATA_WIDTH-1:0]   ram_wdata_o,
`ifdef SP_RAM_ARB_PERF_EN
   input  logic [DATA_WIDTH-1:0]   ram_rdata_i,
   output logic [31:0]             m0_wait_cnt_o,
   output logic [31:0]             m1_wait_cnt_o
`else
   input  logic [DATA_WIDTH-1:0]   ram_rdata_i
`endif
);

   localparam int unsigned CntW = $clog2(MAX_BURST + 1);
   localparam logic [CntW-1:0] BurstMax = CntW'(MAX_BURST);

   logic            m0_req, m1_req;
   logic            grant_any, winner;
   logic            last_owner_q, last_owner_d;
   logic [CntW-1:0] burst_cnt_q, burst_cnt_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic            rsp_owner_q, rsp_owner_d;

   assign m0_req    = m0_req_i & ~rst_i;
   assign m1_req    = m1_req_i & ~rst_i;
   assign grant_any = m0_req | m1_req;

   always_comb begin
      winner = last_owner_q;
      if (m0_req && m1_req) begin
         // A zero count means the previous cycle was idle, so there is no burst to continue.
         if (burst_cnt_q != '0 && burst_cnt_q < BurstMax) begin
            winner = last_owner_q;
         end else begin
            winner = ~last_owner_q;
         end
      end else if (m0_req) begin
         winner = 1'b0;
      end else if (m1_req) begin
         winner = 1'b1;
      end
   end

   assign m0_gnt_o = grant_any & ~winner;
   assign m1_gnt_o = grant_any & winner;

   always_comb begin
      ram_en_o    = grant_any;
      ram_addr_o  = '0;
      ram_we_o    = 1'b0;
      ram_be_o    = '0;
      ram_wdata_o = '0;
      if (m0_gnt_o) begin
         ram_addr_o  = m0_addr_i;
         ram_we_o    = m0_we_i;
         ram_be_o    = m0_be_i;
         ram_wdata_o = m0_wdata_i;
      end else if (m1_gnt_o) begin
         ram_addr_o  = m1_addr_i;
         ram_we_o    = m1_we_i;
         ram_be_o    = m1_be_i;
         ram_wdata_o = m1_wdata_i;
      end
   end

   always_comb begin
      last_owner_d = last_owner_q;
      burst_cnt_d  = burst_cnt_q;
      rsp_valid_d  = grant_any;
      rsp_owner_d  = winner;
      if (!grant_any) begin
         burst_cnt_d = '0;
      end else if (winner == last_owner_q) begin
         if (burst_cnt_q < BurstMax) begin
            burst_cnt_d = burst_cnt_q + CntW'(1);
         end
      end else begin
         last_owner_d = winner;
         burst_cnt_d  = CntW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         last_owner_q <= 1'b1;
         burst_cnt_q  <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_owner_q  <= 1'b0;
      end else begin
         last_owner_q <= last_owner_d;
         burst_cnt_q  <= burst_cnt_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_owner_q  <= rsp_owner_d;
      end
   end

   assign m0_rvalid_o = rsp_valid_q & ~rsp_owner_q;
   assign m1_rvalid_o = rsp_valid_q & rsp_owner_q;
   assign m0_rdata_o  = m0_rvalid_o ? ram_rdata_i : '0;
   assign m1_rdata_o  = m1_rvalid_o ? ram_rdata_i : '0;

`ifdef SP_RAM_ARB_PERF_EN
   logic [31:0] m0_wait_q, m0_wait_d;
   logic [31:0] m1_wait_q, m1_wait_d;

   always_comb begin
      m0_wait_d = m0_wait_q;
      m1_wait_d = m1_wait_q;
      if (m0_req && !m0_gnt_o) m0_wait_d = m0_wait_q + 32'd1;
      if (m1_req && !m1_gnt_o) m1_wait_d = m1_wait_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         m0_wait_q <= '0;
         m1_wait_q <= '0;
      end else begin
         m0_wait_q <= m0_wait_d;
         m1_wait_q <= m1_wait_d;
      end
   end

   assign m0_wait_cnt_o = m0_wait_q;
   assign m1_wait_cnt_o = m1_wait_q;
`endif

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed self-checking bench for sp_ram_arbiter with a small behavioural RAM responder.
// Define SP_RAM_ARB_PERF_EN to also exercise the wait counters.
module tb_sp_ram_arbiter;

   logic        clk;
   logic        rst_i;
   logic        m0_req, m0_gnt, m0_we, m0_rvalid;
   logic [14:0] m0_addr;
   logic [3:0]  m0_be;
   logic [31:0] m0_wdata, m0_rdata;
   logic        m1_req, m1_gnt, m1_we, m1_rvalid;
   logic [14:0] m1_addr;
   logic [3:0]  m1_be;
   logic [31:0] m1_wdata, m1_rdata;
   logic        ram_en, ram_we;
   logic [14:0] ram_addr;
   logic [3:0]  ram_be;
   logic [31:0] ram_wdata, ram_rdata;
`ifdef SP_RAM_ARB_PERF_EN
   logic [31:0] m0_wait_cnt, m1_wait_cnt;
`endif

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [31:0] mem [0:63];

   sp_ram_arbiter #(
      .ADDR_WIDTH(15),
      .DATA_WIDTH(32),
      .MAX_BURST (8)
   ) dut (
      .clk        (clk),
      .rst_i      (rst_i),
      .m0_req_i   (m0_req),
      .m0_gnt_o   (m0_gnt),
      .m0_addr_i  (m0_addr),
      .m0_we_i    (m0_we),
      .m0_be_i    (m0_be),
      .m0_wdata_i (m0_wdata),
      .m0_rvalid_o(m0_rvalid),
      .m0_rdata_o (m0_rdata),
      .m1_req_i   (m1_req),
      .m1_gnt_o   (m1_gnt),
      .m1_addr_i  (m1_addr),
      .m1_we_i    (m1_we),
      .m1_be_i    (m1_be),
      .m1_wdata_i (m1_wdata),
      .m1_rvalid_o(m1_rvalid),
      .m1_rdata_o (m1_rdata),
      .ram_en_o   (ram_en),
      .ram_addr_o (ram_addr),
      .ram_we_o   (ram_we),
      .ram_be_o   (ram_be),
      .ram_wdata_o(ram_wdata),
`ifdef SP_RAM_ARB_PERF_EN
      .ram_rdata_i(ram_rdata),
      .m0_wait_cnt_o(m0_wait_cnt),
      .m1_wait_cnt_o(m1_wait_cnt)
`else
      .ram_rdata_i(ram_rdata)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One-cycle-latency RAM with byte enables, word-indexed over a small window.
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
               if (ram_be[b]) mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
         end else begin
            ram_rdata <= mem[ram_addr[7:2]];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      m0_req = 1'b0; m0_addr = '0; m0_we = 1'b0; m0_be = '0; m0_wdata = '0;
      m1_req = 1'b0; m1_addr = '0; m1_we = 1'b0; m1_be = '0; m1_wdata = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_i = 1'b1;
      next_cycle();
      rst_i = 1'b0;
   endtask

   logic exp_owner, prev_owner;

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = '0;
      mem[4]    = 32'hDEAD_BEEF;
      ram_rdata = '0;
      idle_inputs();

      // Reset with both masters requesting: nothing granted, nothing returned.
      rst_i  = 1'b1;
      m0_req = 1'b1;
      m1_req = 1'b1;
      next_cycle();
      @(negedge clk);
      check("rst_m0_gnt", {31'd0, m0_gnt}, 32'd0);
      check("rst_m1_gnt", {31'd0, m1_gnt}, 32'd0);
      check("rst_ram_en", {31'd0, ram_en}, 32'd0);
      check("rst_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
      check("rst_ram_addr", {17'd0, ram_addr}, 32'd0);
`ifdef SP_RAM_ARB_PERF_EN
      check("rst_wait0", m0_wait_cnt, 32'd0);
      check("rst_wait1", m1_wait_cnt, 32'd0);
`endif
      next_cycle();
      idle_inputs();
      rst_i = 1'b0;

      // Test 1: M0 single read.
      m0_req  = 1'b1;
      m0_addr = 15'h0010;
      @(negedge clk);
      check("t1_m0_gnt", {31'd0, m0_gnt}, 32'd1);
      check("t1_m1_gnt", {31'd0, m1_gnt}, 32'd0);
      check("t1_ram_en", {31'd0, ram_en}, 32'd1);
      check("t1_ram_addr", {17'd0, ram_addr}, 32'h10);
      check("t1_ram_we", {31'd0, ram_we}, 32'd0);
      next_cycle();
      idle_inputs();
      @(negedge clk);
      check("t1_m0_rvalid", {31'd0, m0_rvalid}, 32'd1);
      check("t1_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
      check("t1_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
      check("t1_m1_rdata", m1_rdata, 32'd0);
      check("t1_ram_en_idle", {31'd0, ram_en}, 32'd0);
      next_cycle();

      // Test 2: continuous contention from reset, blocks of 8 grants.
      do_reset();
      m0_req  = 1'b1;
      m0_addr = 15'h0020;
      m1_req  = 1'b1;
      m1_addr = 15'h0040;
      prev_owner = 1'b0;
      for (int i = 0; i < 32; i++) begin
         exp_owner = ((i / 8) % 2) != 0;
         @(negedge clk);
         check("t2_m0_gnt", {31'd0, m0_gnt}, {31'd0, ~exp_owner});
         check("t2_m1_gnt", {31'd0, m1_gnt}, {31'd0, exp_owner});
         if (i == 0) check("t2_addr_m0", {17'd0, ram_addr}, 32'h20);
         if (i == 8) check("t2_addr_m1", {17'd0, ram_addr}, 32'h40);
         if (i > 0) begin
            check("t2_m0_rvalid", {31'd0, m0_rvalid}, {31'd0, ~prev_owner});
            check("t2_m1_rvalid", {31'd0, m1_rvalid}, {31'd0, prev_owner});
         end
`ifdef SP_RAM_ARB_PERF_EN
         if (i == 16) begin
            check("t6_wait0", m0_wait_cnt, 32'd8);
            check("t6_wait1", m1_wait_cnt, 32'd8);
         end
`endif
         prev_owner = exp_owner;
         next_cycle();
      end
      idle_inputs();
      next_cycle();

      // Test 3: M1 partial write, then M0 reads the word back.
      do_reset();
      m1_req   = 1'b1;
      m1_we    = 1'b1;
      m1_addr  = 15'h0008;
      m1_be    = 4'b0011;
      m1_wdata = 32'hAABB_CCDD;
      @(negedge clk);
      check("t3_m1_gnt", {31'd0, m1_gnt}, 32'd1);
      check("t3_ram_we", {31'd0, ram_we}, 32'd1);
      check("t3_ram_be", {28'd0, ram_be}, 32'h3);
      check("t3_ram_wdata", ram_wdata, 32'hAABB_CCDD);
      next_cycle();
      idle_inputs();
      m0_req  = 1'b1;
      m0_addr = 15'h0008;
      @(negedge clk);
      check("t3_m1_rvalid", {31'd0, m1_rvalid}, 32'd1);
      check("t3_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
      check("t3_rd_gnt", {31'd0, m0_gnt}, 32'd1);
      next_cycle();
      idle_inputs();
      @(negedge clk);
      check("t3_readback", m0_rdata, 32'h0000_CCDD);
      next_cycle();

      // Test 4: M0 requests 3 cycles, M1 continuous.
      do_reset();
      m1_req = 1'b1;
      for (int i = 0; i < 8; i++) begin
         m0_req = (i < 3);
         @(negedge clk);
         check("t4_m0_gnt", {31'd0, m0_gnt}, (i < 3) ? 32'd1 : 32'd0);
         check("t4_m1_gnt", {31'd0, m1_gnt}, (i < 3) ? 32'd0 : 32'd1);
         next_cycle();
      end
      idle_inputs();
      next_cycle();

      // Test 5: reset right after a grant swallows the pending response.
      do_reset();
      m0_req  = 1'b1;
      m0_addr = 15'h0010;
      @(negedge clk);
      check("t5_m0_gnt", {31'd0, m0_gnt}, 32'd1);
      next_cycle();
      idle_inputs();
      rst_i = 1'b1;
      @(negedge clk);
      check("t5_rst_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
      check("t5_rst_rdata", m0_rdata, 32'd0);
      next_cycle();
      rst_i = 1'b0;
      @(negedge clk);
      check("t5_post_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
      next_cycle();
      m0_req = 1'b1;
      m1_req = 1'b1;
      @(negedge clk);
      check("t5_m0_first", {31'd0, m0_gnt}, 32'd1);
      check("t5_m1_wait", {31'd0, m1_gnt}, 32'd0);
      next_cycle();
      idle_inputs();
      next_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
